// File: rtl/add_nibble_seq.sv
// Nibble-serial adder: one shared 4-bit ripple adder
// sequenced over N cycles to add two 4N-bit operands.

module add_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_s,
    output logic       o_c
);

    logic [4:0] w_c;

    assign w_c[0] = i_c;

    // four chained full adders
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
        assign o_s[gi]   = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1] = (i_a[gi] & i_b[gi])
                         | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_c = w_c[4];

endmodule

module add_nibble_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic           ci,
    input  logic [4*N-1:0] x,
    input  logic [4*N-1:0] y,
    output logic           ack,
    output logic           busy,
    output logic           co,
    output logic [4*N-1:0] r
);

    localparam int W  = 4 * N;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_xs;
    logic [W-1:0]  r_ys;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  r_r;
    logic          r_c;
    logic          r_co;
    logic [CW-1:0] r_cnt;

    logic [3:0]    w_sum;
    logic          w_cout;
    logic [W-1:0]  w_acc_nxt;
    logic          w_last;

    add_4bit u_add (
        .i_a (r_xs[3:0]),
        .i_b (r_ys[3:0]),
        .i_c (r_c),
        .o_s (w_sum),
        .o_c (w_cout)
    );

    // new nibble enters at the top; after N shifts the
    // LSB nibble has reached bit 0
    if (N == 1) begin : g_one
        assign w_acc_nxt = w_sum;
    end else begin : g_multi
        assign w_acc_nxt = {w_sum, r_acc[W-1:4]};
    end

    assign w_last = (r_cnt == LAST);

    // control FSM: IDLE -> RUN (N cycles) -> DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (req)    r_state <= S_RUN;
                S_RUN:   if (w_last) r_state <= S_DONE;
                S_DONE:  if (!req)   r_state <= S_IDLE;
                default:             r_state <= S_IDLE;
            endcase
        end
    end

    // operand capture, nibble shifting and result latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_xs  <= '0;
            r_ys  <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_acc <= '0;
            r_r   <= '0;
            r_co  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_xs  <= x;
                        r_ys  <= y;
                        r_c   <= ci;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_c   <= w_cout;
                    r_xs  <= r_xs >> 4;
                    r_ys  <= r_ys >> 4;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_r  <= w_acc_nxt;
                        r_co <= w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack  = (r_state == S_DONE);
    assign busy = (r_state != S_IDLE);
    assign co   = r_co;
    assign r    = r_r;

endmodule

// File: tb/tb_add_nibble_seq.sv
// Bench for add_nibble_seq: N=4 and N=1 instances
// against a transaction-level model of x+y+ci.

module tb_add_nibble_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        req0 = 1'b0;
    logic        ci0  = 1'b0;
    logic [15:0] x0   = '0;
    logic [15:0] y0   = '0;
    logic        ack0, busy0, co0;
    logic [15:0] r0;

    logic        req1 = 1'b0;
    logic        ci1  = 1'b0;
    logic [3:0]  x1   = '0;
    logic [3:0]  y1   = '0;
    logic        ack1, busy1, co1;
    logic [3:0]  r1;

    int compared   = 0;
    int mismatched = 0;
    bit en         = 1'b0;

    always #5 clk = ~clk;

    add_nibble_seq #(.N(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .req  (req0),
        .ci   (ci0),
        .x    (x0),
        .y    (y0),
        .ack  (ack0),
        .busy (busy0),
        .co   (co0),
        .r    (r0)
    );

    add_nibble_seq #(.N(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .req  (req1),
        .ci   (ci1),
        .x    (x1),
        .y    (y1),
        .ack  (ack1),
        .busy (busy1),
        .co   (co1),
        .r    (r1)
    );

    // transaction model: phase 0 idle, 1 computing, 2 result shown
    int          m_ph[2];
    int          m_left[2];
    logic [16:0] m_pend[2];
    logic [16:0] m_out[2];
    logic        m_rq;
    int          m_n;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_rq = (d == 0) ? req0 : req1;
            m_n  = (d == 0) ? 4 : 1;
            if (rst) begin
                m_ph[d]  = 0;
                m_out[d] = '0;
            end else if (m_ph[d] == 0) begin
                if (m_rq) begin
                    if (d == 0)
                        m_pend[d] = 17'(x0) + 17'(y0) + 17'(ci0);
                    else
                        m_pend[d] = {12'd0, 5'(x1) + 5'(y1) + 5'(ci1)};
                    m_left[d] = m_n;
                    m_ph[d]   = 1;
                end
            end else if (m_ph[d] == 1) begin
                m_left[d]--;
                if (m_left[d] == 0) begin
                    m_out[d] = m_pend[d];
                    m_ph[d]  = 2;
                end
            end else begin
                if (!m_rq) m_ph[d] = 0;
            end
        end
    end

    // every-cycle comparison of both DUTs against the model
    always @(negedge clk) begin
        if (en) begin
            for (int d = 0; d < 2; d++) begin
                logic [18:0] act, exp;
                if (d == 0) act = {ack0, busy0, co0, r0};
                else        act = {ack1, busy1, 12'd0, co1, r1};
                exp = {m_ph[d] == 2, m_ph[d] != 0, m_out[d]};
                compared++;
                if (act !== exp) begin
                    mismatched++;
                    $display("FAIL cycle dut%0d @%0t: ack/busy/co/r got %h expected %h",
                             d, $time, act, exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // called at a negedge with the N=4 DUT idle
    task automatic run0(input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] er,
                        input logic eco, input string nm);
        int i;
        req0 = 1'b1; x0 = a; y0 = b; ci0 = c;
        @(posedge clk);
        for (i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) chk({nm, " busy"}, 32'(busy0), 32'd1);
            if (ack0) break;
        end
        chk({nm, " latency"}, i, 4);
        chk({nm, " r"}, 32'(r0), 32'(er));
        chk({nm, " co"}, 32'(co0), 32'(eco));
        req0 = 1'b0;
        @(negedge clk);
        chk({nm, " idle"}, {ack0, busy0}, 32'd0);
        chk({nm, " hold"}, 32'(r0), 32'(er));
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i, nack;
        logic [15:0] seen;

        // reset with a pending request
        rst = 1'b1; req0 = 1'b1; x0 = 16'hFFFF; y0 = '0; ci0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("reset outs", {ack0, busy0, co0, r0}, 32'd0);
        rst = 1'b0;
        run0(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, "first accept");

        run0(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "basic");
        chk("model pin", 32'(m_out[0]), 32'h0_5555);
        run0(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "ripple1");
        run0(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, "ripple2");

        // reset during the second RUN cycle
        req0 = 1'b1; x0 = 16'h00FF; y0 = 16'h0001; ci0 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1; req0 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrun reset", {ack0, busy0, co0, r0}, 32'd0);
        nack = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack0) nack++;
        end
        chk("no stale ack", nack, 0);
        run0(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "after reset");

        // inputs change and req drops right after accept
        req0 = 1'b1; x0 = 16'h0F0F; y0 = 16'h0101; ci0 = 1'b0;
        @(posedge clk);
        #1 x0 = 16'hFFFF; req0 = 1'b0;
        nack = 0; seen = '0; i = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack0) begin
                nack++;
                seen = r0;
                if (i < 0) i = k;
            end
        end
        chk("drop ack cycles", nack, 1);
        chk("drop latency", i, 4);
        chk("drop r", 32'(seen), 32'h1010);
        chk("drop co", 32'(co0), 32'd0);

        // random back-to-back traffic on both instances
        fork
            begin
                for (int t = 0; t < 1000; t++) begin
                    int j;
                    req0 = 1'b1;
                    x0 = 16'($urandom); y0 = 16'($urandom);
                    ci0 = 1'($urandom);
                    @(posedge clk);
                    for (j = 0; j < 8; j++) begin
                        @(negedge clk);
                        if (ack0) break;
                        if ($urandom_range(0, 1) == 1) x0 = 16'($urandom);
                        if ($urandom_range(0, 7) == 0) req0 = 1'b0;
                    end
                    chk("rand4 latency", j, 4);
                    req0 = 1'b0;
                    @(negedge clk);
                end
            end
            begin
                for (int t = 0; t < 1000; t++) begin
                    int j;
                    req1 = 1'b1;
                    x1 = 4'($urandom); y1 = 4'($urandom);
                    ci1 = 1'($urandom);
                    @(posedge clk);
                    for (j = 0; j < 5; j++) begin
                        @(negedge clk);
                        if (ack1) break;
                    end
                    chk("rand1 latency", j, 1);
                    req1 = 1'b0;
                    y1 = 4'($urandom);
                    @(negedge clk);
                end
            end
        join

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
